// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-outstanding memory responder backed by DEPTH 64-bit doublewords.
//   Each accepted request is held for WAIT_CYCLES wait states. The storage
//   access then happens, and the result is held in RESP until the initiator
//   takes it.
//
//   State walk: IDLE --accept--> WAIT --counter==0--> RESP --handshake--> IDLE
//
// Ports
//   clk_div     in   1   sole clock, rising edge
//   rst         in   1   synchronous, active-high reset
//   req_valid   in   1   initiator presents a request
//   req_ready   out  1   responder accepts a request this cycle (IDLE only)
//   req_write   in   1   1 = store, 0 = load
//   req_addr    in   64  byte address (doubleword index = addr[63:3])
//   req_wdata   in   64  store data
//   resp_valid  out  1   response available (RESP only)
//   resp_ready  in   1   initiator consumes the response
//   resp_rdata  out  64  load data; 0 for stores, errors and outside RESP
//   resp_err    out  1   request was misaligned or out of range
//   busy        out  1   high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic               ready_r;
    logic               valid_r;
    logic               busy_r;
    logic               ready_nxt_s;
    logic               valid_nxt_s;
    logic               busy_nxt_s;

    logic [3:0]         cnt_r;
    logic               write_r;
    logic [63:0]        addr_r;
    logic [63:0]        wdata_r;
    logic [63:0]        rdata_r;
    logic               err_r;
    logic [63:0]        mem_r [DEPTH];

    logic               accept_s;
    logic               access_s;
    logic               wait_dec_s;
    logic               release_s;
    logic               bad_s;
    logic [IDX_W-1:0]   idx_s;

    // A request faults when it is not doubleword aligned or its index lies past the array.
    function automatic logic access_fault(input logic [63:0] addr);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[2:0] != 3'b000);
        out_of_range = (addr[63:3] >= 61'(DEPTH));
        return misaligned || out_of_range;
    endfunction

    assign accept_s   = (state_r == ST_IDLE) && req_valid;
    assign access_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    assign wait_dec_s = (state_r == ST_WAIT) && (cnt_r != 4'd0);
    assign release_s  = (state_r == ST_RESP) && resp_ready;
    assign bad_s      = access_fault(addr_r);
    assign idx_s      = addr_r[3 +: IDX_W];

    // Next-state decision for the IDLE/WAIT/RESP sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so that they can be registered.
    always_comb begin
        ready_nxt_s = 1'b0;
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_IDLE: ready_nxt_s = 1'b1;
            ST_WAIT: busy_nxt_s  = 1'b1;
            ST_RESP: begin
                valid_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
            end
            default: ready_nxt_s = 1'b1;
        endcase
    end

    // State register together with its registered handshake flags.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= ready_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            cnt_r   <= 4'd0;
            write_r <= 1'b0;
            addr_r  <= 64'd0;
            wdata_r <= 64'd0;
            rdata_r <= 64'd0;
            err_r   <= 1'b0;
        end else begin
            // Fields are only captured in IDLE, so the req_* inputs are ignored in WAIT and RESP.
            if (accept_s) begin
                write_r <= req_write;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                cnt_r   <= WAIT_LOAD;
            end else if (wait_dec_s) begin
                cnt_r <= cnt_r - 4'd1;
            end
            // The response is held until the handshake, then returns to zero.
            if (access_s) begin
                err_r   <= bad_s;
                rdata_r <= (bad_s || write_r) ? 64'd0 : mem_r[idx_s];
            end else if (release_s) begin
                err_r   <= 1'b0;
                rdata_r <= 64'd0;
            end
        end
    end

    // Storage array; a store lands only at its access edge, so reset before that edge drops it.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
        end else if (access_s && write_r && !bad_s) begin
            mem_r[idx_s] <= wdata_r;
        end
    end

    // req_ready is forced low while reset is held, even though the state already reads IDLE.
    assign req_ready  = ready_r & ~rst;
    assign resp_valid = valid_r;
    assign resp_rdata = rdata_r;
    assign resp_err   = err_r;
    assign busy       = busy_r;

endmodule
